multicycle_mainfsm: RTL and testbench
=====================================

Name: multicycle_mainfsm

Overview:
- Moore-style main sequencer for the multicycle ARM datapath, with one shared memory for instructions and data.
- Steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects and write strobes.
- Adds a memory wait-state handshake (MemReady) so slow memory can stall FETCH, MEMREAD and MEMWRITE.
- Sits inside the controller, alongside the existing ALU decoder and condlogic. RegW, MemW and Branch leave this block unconditioned; condlogic gates them with CondEx.

Parameters:
- CNT_WIDTH, 32, width of the performance counters (used only with PERF_CNT_EN).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20].
- MemReady  in  1  memory completes the current access this cycle.
- IRWrite  out  1  load the instruction register.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ALUSrcA  out  1  0 = register A, 1 = PC.
- ALUSrcB  out  2  00 = reg B, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- NextPC  out  1  PC write strobe (unconditional).
- RegW  out  1  register write request (pre-condition).
- MemW  out  1  memory write request (pre-condition).
- Branch  out  1  branch request (pre-condition).
- ALUOp  out  1  1 = ALU decoder uses Funct; 0 = add.
- Illegal  out  1  one-cycle pulse, undefined Op seen in DECODE.
- State  out  4  current state encoding, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
- Encodings 10 to 15 are unreachable. If entered, the next state is FETCH and all strobes are 0.
- Reset, asynchronous: State=FETCH. While reset is high, all strobes (IRWrite, NextPC, RegW, MemW, Branch, Illegal) are forced to 0. Selects take their FETCH values.
- Transitions and outputs per state. Any select not listed is 0; ALUOp is 0 unless listed.
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. IRWrite=NextPC=MemReady. Moves to DECODE only when MemReady=1, otherwise holds.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
    - Op=01 -> MEMADR.
    - Op=00 with Funct[5]=0 -> EXECUTER.
    - Op=00 with Funct[5]=1 -> EXECUTEI.
    - Op=10 -> BRANCH.
    - Op=11 -> FETCH, with Illegal=1 for that cycle.
  - MEMADR: ALUSrcA=0, ALUSrcB=01. Funct[0]=1 -> MEMREAD, else -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady=1, then -> MEMWB.
  - MEMWB: ResultSrc=01, RegW=1. Then -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00. MemW=1 every cycle in this state, held stable until MemReady=1, then -> FETCH.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Then -> ALUWB.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Then -> ALUWB.
  - ALUWB: ResultSrc=00, RegW=1. Then -> FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1. Then -> FETCH.
- Latency with MemReady tied high:
  - Data processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
- Each wait cycle adds one cycle in the stalled state.
- Op and Funct are sampled only in DECODE and MEMADR. Their values in other states are ignored.
- Reset asserted mid-instruction returns State to FETCH immediately. No strobe is asserted after reset rises.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined: two extra outputs are added.
  - CycleCount [CNT_WIDTH-1:0]: increments every non-reset cycle.
  - InstrCount [CNT_WIDTH-1:0]: increments on every transition into FETCH from any state other than FETCH. The DECODE->FETCH transition on an illegal Op counts.
  - Both counters reset to 0 and wrap modulo 2^CNT_WIDTH.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mcyc_pkg holds:
  - the state enum (4-bit, values above);
  - the ALUSrcB encodings (SRCB_REG, SRCB_IMM, SRCB_FOUR);
  - the ResultSrc encodings (RES_ALUOUT, RES_DATA, RES_ALU);
  - the Op encodings (OP_DP, OP_MEM, OP_BR).
- One natural sub-module: mainfsm_outdec, a purely combinational decoder from state and MemReady to the output vector.
- The state register and next-state logic stay in the top module.

Test Plan:
- Reset held 3 cycles, then released with MemReady=1 -> State=0, all strobes 0 during reset; IRWrite=NextPC=1 in the first cycle after release.
- ADD register form (Op=00, Funct=001000), MemReady=1 -> states 0,1,6,8,0; ALUOp=1 in EXECUTER; RegW=1 only in ALUWB.
- LDR (Op=01, Funct=011001), MemReady low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; AdrSrc=1 throughout MEMREAD; RegW=1 with ResultSrc=01 in MEMWB.
- STR (Funct[0]=0), MemReady low 1 cycle in MEMWRITE -> MemW=1 for 2 consecutive cycles; RegW never 1.
- B (Op=10), then Op=11 -> BRANCH with Branch=1 and ALUSrcB=01. The Op=11 instruction goes DECODE->FETCH with Illegal=1 for exactly one cycle.
- With PERF_CNT_EN defined, CNT_WIDTH=4, and 17 single-cycle-memory data-processing instructions -> InstrCount wraps to 1 and CycleCount equals 68 mod 16 = 4.

Source files
------------

// File: rtl/multicycle_mainfsm_pkg.sv
// Shared types and encodings for the multicycle ARM main sequencer.
package mcyc_pkg;

    // Sequencer states; encodings 10..15 are never entered in normal operation.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // ALUSrcB mux selects.
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc mux selects.
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Instruction class from Instr[27:26]; 2'b11 is undefined.
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Full control vector driven towards the datapath.
    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_mainfsm_if.sv
// Controller-side bundle between the datapath and the main sequencer.
// PERF_CNT_EN adds the CycleCount/InstrCount counter outputs and the
// CNT_WIDTH parameter that sizes them.
interface multicycle_mainfsm_if
`ifdef PERF_CNT_EN
    #(parameter int CNT_WIDTH = 32)
`endif
    ;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic       Illegal;
    logic [3:0] State;
`ifdef PERF_CNT_EN
    logic [CNT_WIDTH-1:0] CycleCount;
    logic [CNT_WIDTH-1:0] InstrCount;

    modport master (
        output Op, Funct, MemReady,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
               RegW, MemW, Branch, ALUOp, Illegal, State, CycleCount, InstrCount
    );
    modport slave (
        input  Op, Funct, MemReady,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
               RegW, MemW, Branch, ALUOp, Illegal, State, CycleCount, InstrCount
    );
`else
    modport master (
        output Op, Funct, MemReady,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
               RegW, MemW, Branch, ALUOp, Illegal, State
    );
    modport slave (
        input  Op, Funct, MemReady,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
               RegW, MemW, Branch, ALUOp, Illegal, State
    );
`endif
endinterface

// File: rtl/multicycle_mainfsm_outdec.sv
// Moore output decoder: state (plus MemReady in FETCH and Op in DECODE)
// to the datapath control vector.
module mainfsm_outdec
    import mcyc_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [1:0] op,
    output ctrl_t      ctrl
);

    // Everything defaults to 0; each state raises only what it needs.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = mem_ready;
                ctrl.next_pc    = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
                ctrl.illegal    = (op == 2'b11);
            end
            S_MEMADR: begin
                ctrl.alu_src_b  = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_w      = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_op     = 1'b1;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = 1'b1;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALU;
                ctrl.branch     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_mainfsm.sv
// Main sequencer for the multicycle ARM datapath with memory wait states.
// PERF_CNT_EN adds cycle and retired-instruction counters of CNT_WIDTH bits.
module multicycle_mainfsm
    import mcyc_pkg::*;
`ifdef PERF_CNT_EN
#(
    parameter int CNT_WIDTH = 32
)
`endif
(
    input logic                  clk,
    input logic                  reset,
    multicycle_mainfsm_if.slave  bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl_out;

`ifdef PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cycle_cnt_q;
    logic [CNT_WIDTH-1:0] cycle_cnt_d;
    logic [CNT_WIDTH-1:0] instr_cnt_q;
    logic [CNT_WIDTH-1:0] instr_cnt_d;
`endif

    // Next-state logic; Op/Funct only matter in DECODE and MEMADR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

`ifdef PERF_CNT_EN
    // Counters: every clocked cycle, and every re-entry into FETCH.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
        instr_cnt_d = instr_cnt_q;
        if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
            instr_cnt_d = instr_cnt_q + CNT_WIDTH'(1);
        end
    end
`endif

    // Sequencer state register (and counters when enabled).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
`ifdef PERF_CNT_EN
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
`ifdef PERF_CNT_EN
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
`endif
        end
    end

    mainfsm_outdec u_outdec (
        .state     (state_q),
        .mem_ready (bus.MemReady),
        .op        (bus.Op),
        .ctrl      (ctrl_raw)
    );

    // Reset suppresses every strobe immediately, even though FETCH would
    // otherwise echo MemReady onto IRWrite/NextPC.
    always_comb begin
        ctrl_out = ctrl_raw;
        if (reset) begin
            ctrl_out.ir_write = 1'b0;
            ctrl_out.next_pc  = 1'b0;
            ctrl_out.reg_w    = 1'b0;
            ctrl_out.mem_w    = 1'b0;
            ctrl_out.branch   = 1'b0;
            ctrl_out.illegal  = 1'b0;
        end
    end

    assign bus.IRWrite   = ctrl_out.ir_write;
    assign bus.AdrSrc    = ctrl_out.adr_src;
    assign bus.ALUSrcA   = ctrl_out.alu_src_a;
    assign bus.ALUSrcB   = ctrl_out.alu_src_b;
    assign bus.ResultSrc = ctrl_out.result_src;
    assign bus.NextPC    = ctrl_out.next_pc;
    assign bus.RegW      = ctrl_out.reg_w;
    assign bus.MemW      = ctrl_out.mem_w;
    assign bus.Branch    = ctrl_out.branch;
    assign bus.ALUOp     = ctrl_out.alu_op;
    assign bus.Illegal   = ctrl_out.illegal;
    assign bus.State     = state_q;

`ifdef PERF_CNT_EN
    assign bus.CycleCount = cycle_cnt_q;
    assign bus.InstrCount = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_mainfsm.sv
// Bench for multicycle_mainfsm: per-cycle vector table through a scoreboard,
// plus hand sequences for async reset and (with PERF_CNT_EN) counter wrap.
module tb_multicycle_mainfsm;

    // Per-cycle record: inputs for the cycle and the outputs expected in it.
    typedef struct {
        logic       rst;
        logic [1:0] op;
        logic [5:0] funct;
        logic       rdy;
        logic [3:0] st;
        logic [6:0] strb;
        logic [5:0] sel;
    } vec_t;

    // Expected outputs waiting in the scoreboard.
    typedef struct {
        string      name;
        logic [3:0] st;
        logic [6:0] strb;
        logic [5:0] sel;
    } exp_t;

    // Strobes {IRWrite,NextPC,RegW,MemW,Branch,Illegal,ALUOp}.
    localparam logic [6:0] N_NONE = 7'b0000000;
    localparam logic [6:0] N_FET  = 7'b1100000;
    localparam logic [6:0] N_REGW = 7'b0010000;
    localparam logic [6:0] N_MEMW = 7'b0001000;
    localparam logic [6:0] N_BR   = 7'b0000100;
    localparam logic [6:0] N_ILL  = 7'b0000010;
    localparam logic [6:0] N_ALUO = 7'b0000001;

    // Selects {AdrSrc,ALUSrcA,ALUSrcB[1:0],ResultSrc[1:0]} by state.
    localparam logic [5:0] L_FET  = 6'b0_1_10_10;
    localparam logic [5:0] L_MADR = 6'b0_0_01_00;
    localparam logic [5:0] L_MEM  = 6'b1_0_00_00;
    localparam logic [5:0] L_MWB  = 6'b0_0_00_01;
    localparam logic [5:0] L_EXR  = 6'b0_0_00_00;
    localparam logic [5:0] L_EXI  = 6'b0_0_01_00;
    localparam logic [5:0] L_AWB  = 6'b0_0_00_00;
    localparam logic [5:0] L_BR   = 6'b0_0_01_10;

    localparam logic [1:0] JOP = 2'b11;
    localparam logic [5:0] JFN = 6'h3F;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    vec_t vecs[$];
    exp_t sb[$];

`ifdef PERF_CNT_EN
    multicycle_mainfsm_if #(.CNT_WIDTH(4)) bus ();
    multicycle_mainfsm #(.CNT_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
    multicycle_mainfsm_if bus ();
    multicycle_mainfsm dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [1:0] o, logic [5:0] f, logic d,
                                logic [3:0] s, logic [6:0] n, logic [5:0] l);
        vec_t v;
        v.rst = r; v.op = o; v.funct = f; v.rdy = d;
        v.st = s; v.strb = n; v.sel = l;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v, input string name);
        exp_t e;
        reset        = v.rst;
        bus.Op       = v.op;
        bus.Funct    = v.funct;
        bus.MemReady = v.rdy;
        e.name = name; e.st = v.st; e.strb = v.strb; e.sel = v.sel;
        sb.push_back(e);
    endtask

    task automatic check_output();
        exp_t       e;
        logic [6:0] a_strb;
        logic [5:0] a_sel;
        a_strb = {bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.Illegal, bus.ALUOp};
        a_sel  = {bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty actual=none required=entry");
            return;
        end
        e = sb.pop_front();
        if (bus.State !== e.st) begin
            failures++;
            $display("[TB] FAIL %s_state actual=%0d required=%0d", e.name, bus.State, e.st);
        end
        checks++;
        if (a_strb !== e.strb) begin
            failures++;
            $display("[TB] FAIL %s_strobes actual=%b required=%b", e.name, a_strb, e.strb);
        end
        checks++;
        if (a_sel !== e.sel) begin
            failures++;
            $display("[TB] FAIL %s_selects actual=%b required=%b", e.name, a_sel, e.sel);
        end
    endtask

    task automatic check_val(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.Op = JOP;
        bus.Funct = JFN;
        bus.MemReady = 1'b1;

        // Reset held three cycles.
        repeat (3) vecs.push_back(mk(1, JOP, JFN, 1, 4'd0, N_NONE, L_FET));
        // ADD register form, junk Op/Funct outside DECODE.
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd0, N_FET, L_FET));
        vecs.push_back(mk(0, 2'b00, 6'b001000, 1, 4'd1, N_NONE, L_FET));
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd6, N_ALUO, L_EXR));
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd8, N_REGW, L_AWB));
        // LDR with two wait cycles in MEMREAD.
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd0, N_FET, L_FET));
        vecs.push_back(mk(0, 2'b01, 6'b011001, 1, 4'd1, N_NONE, L_FET));
        vecs.push_back(mk(0, JOP, 6'b011001, 1, 4'd2, N_NONE, L_MADR));
        vecs.push_back(mk(0, JOP, JFN, 0, 4'd3, N_NONE, L_MEM));
        vecs.push_back(mk(0, JOP, JFN, 0, 4'd3, N_NONE, L_MEM));
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd3, N_NONE, L_MEM));
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd4, N_REGW, L_MWB));
        // STR with one wait cycle in MEMWRITE.
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd0, N_FET, L_FET));
        vecs.push_back(mk(0, 2'b01, 6'b011000, 1, 4'd1, N_NONE, L_FET));
        vecs.push_back(mk(0, JOP, 6'b011000, 1, 4'd2, N_NONE, L_MADR));
        vecs.push_back(mk(0, JOP, JFN, 0, 4'd5, N_MEMW, L_MEM));
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd5, N_MEMW, L_MEM));
        // Branch.
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd0, N_FET, L_FET));
        vecs.push_back(mk(0, 2'b10, JFN, 1, 4'd1, N_NONE, L_FET));
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd9, N_BR, L_BR));
        // Undefined Op.
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd0, N_FET, L_FET));
        vecs.push_back(mk(0, 2'b11, 6'b001000, 1, 4'd1, N_ILL, L_FET));
        // Immediate DP with a stalled FETCH first.
        vecs.push_back(mk(0, JOP, JFN, 0, 4'd0, N_NONE, L_FET));
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd0, N_FET, L_FET));
        vecs.push_back(mk(0, 2'b00, 6'b101000, 1, 4'd1, N_NONE, L_FET));
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd7, N_ALUO, L_EXI));
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd8, N_REGW, L_AWB));
        vecs.push_back(mk(0, JOP, JFN, 1, 4'd0, N_FET, L_FET));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
            check_output();
        end

        // Now in DECODE: start an ADD and reset it from EXECUTER.
        @(posedge clk);
        #1;
        apply_stimulus(mk(0, 2'b00, 6'b001000, 1, 4'd1, N_NONE, L_FET), "midrst_decode");
        @(negedge clk);
        check_output();
        @(posedge clk);
        #1;
        apply_stimulus(mk(0, JOP, JFN, 1, 4'd6, N_ALUO, L_EXR), "midrst_exec");
        #1;
        check_output();
        #1;
        apply_stimulus(mk(1, JOP, JFN, 1, 4'd0, N_NONE, L_FET), "midrst_async");
        #1;
        check_output();
        @(posedge clk);
        #2;
        apply_stimulus(mk(1, JOP, JFN, 1, 4'd0, N_NONE, L_FET), "midrst_held");
        #1;
        check_output();
        apply_stimulus(mk(0, JOP, JFN, 1, 4'd0, N_FET, L_FET), "midrst_release");
        #1;
        check_output();

`ifdef PERF_CNT_EN
        // Counter wrap: 17 four-cycle DP instructions at CNT_WIDTH=4.
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.Op = 2'b00;
        bus.Funct = 6'b001000;
        bus.MemReady = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_val("cycle_count_reset", int'(bus.CycleCount), 0);
        check_val("instr_count_reset", int'(bus.InstrCount), 0);
        repeat (68) @(posedge clk);
        #1;
        check_val("cycle_count_wrap", int'(bus.CycleCount), 4);
        check_val("instr_count_wrap", int'(bus.InstrCount), 1);
        check_val("perf_state_fetch", int'(bus.State), 0);
`endif

        check_val("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
